// File: rtl/wdata_coalescer.sv
// wdata_coalescer: turns one warp store request into one memory write per
// distinct block address. The lowest-index pending thread leads each write;
// every pending thread sharing its block address is merged into it, with the
// highest thread index winning overlapping bytes.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only while idle)
//   req_tag_i                  request tag, echoed on mem_tag_o
//   req_we_mask_i              per-thread write enable
//   req_wdata_i                per-thread data, thread t at [t*RegWidth +: RegWidth]
//   req_write_width_i          log2 of write size in bytes (shared)
//   req_block_addr_i           per-thread block address
//   req_block_offsets_i        per-thread byte offset within the block
//   mem_valid_o / mem_ready_i  memory write handshake
//   mem_addr_o, mem_we_mask_o, mem_wdata_o, mem_tag_o, mem_last_o  write fields
//   err_o                      one-cycle pulse: a misaligned thread was dropped
//
// Build option: define BGPU_WDATA_COALESCER_MISALIGN_DROP_EN to drop threads
// that are misaligned or cross the block end at acceptance (and pulse err_o).
// Without it, err_o is 0 and such writes are truncated at the block end.
module wdata_coalescer #(
  parameter  int          RegWidth       = 32,
  parameter  int          WarpWidth      = 4,
  parameter  int          BlockIdxBits   = 4,
  parameter  int          BlockAddrWidth = 28,
  parameter  int          TagWidth       = 4,
  localparam int          RegBytes       = (RegWidth + 7) / 8,
  localparam int          WwRaw          = $clog2(RegBytes),
  localparam int          WW             = (WwRaw < 1) ? 1 : WwRaw,
  localparam int unsigned BS             = 2 ** BlockIdxBits
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [TagWidth-1:0]                  req_tag_i,
  input  logic [WarpWidth-1:0]                 req_we_mask_i,
  input  logic [WarpWidth*RegWidth-1:0]        req_wdata_i,
  input  logic [WW-1:0]                        req_write_width_i,
  input  logic [WarpWidth*BlockAddrWidth-1:0]  req_block_addr_i,
  input  logic [WarpWidth*BlockIdxBits-1:0]    req_block_offsets_i,
  output logic                                 mem_valid_o,
  input  logic                                 mem_ready_i,
  output logic [BlockAddrWidth-1:0]            mem_addr_o,
  output logic [BS-1:0]                        mem_we_mask_o,
  output logic [BS*8-1:0]                      mem_wdata_o,
  output logic [TagWidth-1:0]                  mem_tag_o,
  output logic                                 mem_last_o,
  output logic                                 err_o
);

  localparam int        RegPad = RegBytes * 8;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;

  logic [0:0]                          state;
  logic [WarpWidth-1:0]                pending;
  logic [TagWidth-1:0]                 tag_q;
  logic [WarpWidth*RegWidth-1:0]       wdata_q;
  logic [WW-1:0]                       width_q;
  logic [WarpWidth*BlockAddrWidth-1:0] addr_q;
  logic [WarpWidth*BlockIdxBits-1:0]   offs_q;

  logic                      accept;
  logic [WarpWidth-1:0]      accept_mask;
  logic [WarpWidth-1:0]      merge;
  logic [WarpWidth-1:0]      remaining;
  logic [BlockAddrWidth-1:0] leader_addr;
  logic [BS-1:0]             we;
  logic [BS*8-1:0]           wd;

  assign accept = req_valid_i && (state == IDLE);

`ifdef BGPU_WDATA_COALESCER_MISALIGN_DROP_EN
  logic [WarpWidth-1:0] drop;
  logic                 err_q;

  always_comb begin
    int unsigned off;
    int unsigned sz;
    drop = '0;
    off  = 0;
    sz   = 32'd1 << req_write_width_i;
    for (int unsigned t = 0; t < WarpWidth; t++) begin
      off = 32'(req_block_offsets_i[t*BlockIdxBits +: BlockIdxBits]);
      if (req_we_mask_i[t] && (((off & (sz - 1)) != 0) || (off + sz > BS))) begin
        drop[t] = 1'b1;
      end
    end
  end

  assign accept_mask = req_we_mask_i & ~drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && (drop != '0);
    end
  end

  assign err_o = err_q;
`else
  assign accept_mask = req_we_mask_i;
  assign err_o       = 1'b0;
`endif

  // Leader selection, merge set and byte lanes. Threads are walked in
  // ascending order so a later (higher-index) thread overwrites shared bytes.
  always_comb begin
    logic                leader_found;
    int unsigned         off;
    int unsigned         sz;
    int unsigned         k;
    logic [RegPad-1:0]   tbytes;
    leader_found = 1'b0;
    leader_addr  = '0;
    merge        = '0;
    we           = '0;
    wd           = '0;
    off          = 0;
    k            = 0;
    tbytes       = '0;
    sz           = 32'd1 << width_q;
    for (int unsigned t = 0; t < WarpWidth; t++) begin
      if (pending[t] && !leader_found) begin
        leader_found = 1'b1;
        leader_addr  = addr_q[t*BlockAddrWidth +: BlockAddrWidth];
      end
    end
    for (int unsigned t = 0; t < WarpWidth; t++) begin
      merge[t] = pending[t] && (addr_q[t*BlockAddrWidth +: BlockAddrWidth] == leader_addr);
    end
    for (int unsigned t = 0; t < WarpWidth; t++) begin
      off    = 32'(offs_q[t*BlockIdxBits +: BlockIdxBits]);
      tbytes = '0;
      tbytes[RegWidth-1:0] = wdata_q[t*RegWidth +: RegWidth];
      for (int unsigned b = 0; b < BS; b++) begin
        if (merge[t] && (b >= off) && (b < off + sz)) begin
          k     = b - off;
          we[b] = 1'b1;
          if (k < RegBytes) begin
            wd[b*8 +: 8] = tbytes[k*8 +: 8];
          end else begin
            wd[b*8 +: 8] = '0;
          end
        end
      end
    end
  end

  assign remaining     = pending & ~merge;
  assign req_ready_o   = (state == IDLE);
  assign mem_valid_o   = (state == BUSY);
  assign mem_addr_o    = leader_addr;
  assign mem_we_mask_o = we;
  assign mem_wdata_o   = wd;
  assign mem_tag_o     = tag_q;
  assign mem_last_o    = (state == BUSY) && (remaining == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      pending <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
      width_q <= '0;
      addr_q  <= '0;
      offs_q  <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        tag_q   <= req_tag_i;
        wdata_q <= req_wdata_i;
        width_q <= req_write_width_i;
        addr_q  <= req_block_addr_i;
        offs_q  <= req_block_offsets_i;
        pending <= accept_mask;
        state   <= (accept_mask != '0) ? BUSY : IDLE;
      end
    end else begin
      if (mem_ready_i) begin
        pending <= remaining;
        if (remaining == '0) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_wdata_coalescer.sv
// Bench for wdata_coalescer at default parameters (4 threads, 32-bit regs,
// 16-byte blocks). Requests come from a vector table plus hand-written
// sequences; every request's expected writes are queued when it is driven
// and popped as the DUT completes memory handshakes.
module tb_wdata_coalescer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_tag;
  logic [3:0]    req_mask;
  logic [127:0]  req_wdata;
  logic [1:0]    req_width;
  logic [111:0]  req_addr;
  logic [15:0]   req_offs;
  logic          mem_valid;
  logic          mem_ready;
  logic [27:0]   mem_addr;
  logic [15:0]   mem_we;
  logic [127:0]  mem_wdata;
  logic [3:0]    mem_tag;
  logic          mem_last;
  logic          err;

  always #5 clk = ~clk;

  wdata_coalescer dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_tag_i           (req_tag),
    .req_we_mask_i       (req_mask),
    .req_wdata_i         (req_wdata),
    .req_write_width_i   (req_width),
    .req_block_addr_i    (req_addr),
    .req_block_offsets_i (req_offs),
    .mem_valid_o         (mem_valid),
    .mem_ready_i         (mem_ready),
    .mem_addr_o          (mem_addr),
    .mem_we_mask_o       (mem_we),
    .mem_wdata_o         (mem_wdata),
    .mem_tag_o           (mem_tag),
    .mem_last_o          (mem_last),
    .err_o               (err)
  );

  typedef struct {
    logic [3:0]   mask;
    logic [3:0]   tag;
    logic [1:0]   width;
    logic [111:0] addrs;
    logic [15:0]  offs;
    logic [127:0] wdata;
    int           exp_writes;
    logic [27:0]  exp_first_addr;
    logic [15:0]  exp_first_we;
  } vec_t;

  typedef struct {
    logic [27:0]  addr;
    logic [15:0]  we;
    logic [127:0] data;
    logic [3:0]   tag;
    logic         last;
  } wexp_t;

  wexp_t sb[$];
  vec_t  vecs[$];

  int          checks = 0;
  int          errors = 0;
  int          obs_total = 0;
  int          base_total = 0;
  logic [27:0] first_addr;
  logic [15:0] first_we;

  function automatic logic [111:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {28'(a3), 28'(a2), 28'(a1), 28'(a0)};
  endfunction

  function automatic logic [15:0] po(input int o0, input int o1, input int o2, input int o3);
    return {4'(o3), 4'(o2), 4'(o1), 4'(o0)};
  endfunction

  function automatic vec_t mkv(input logic [3:0] mask, input logic [3:0] tag, input logic [1:0] width,
                               input logic [111:0] addrs, input logic [15:0] offs,
                               input logic [127:0] wdata, input int nw,
                               input logic [27:0] fa, input logic [15:0] fw);
    vec_t v;
    v.mask = mask; v.tag = tag; v.width = width; v.addrs = addrs; v.offs = offs;
    v.wdata = wdata; v.exp_writes = nw; v.exp_first_addr = fa; v.exp_first_we = fw;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: groups threads by block address in order of the first
  // enabled thread; each byte is claimed by the highest covering thread.
  task automatic push_model(input vec_t v);
    logic [3:0]  pend;
    logic [3:0]  sel;
    logic [27:0] a;
    int          sz;
    int          off;
    bit          got;
    wexp_t       e;
    pend = v.mask;
    sz   = 1 << v.width;
`ifdef BGPU_WDATA_COALESCER_MISALIGN_DROP_EN
    for (int t = 0; t < 4; t++) begin
      off = int'(v.offs[t*4 +: 4]);
      if ((off % sz) != 0 || off + sz > 16) pend[t] = 1'b0;
    end
`endif
    while (pend != 4'b0) begin
      got = 1'b0;
      a   = '0;
      for (int t = 0; t < 4; t++) begin
        if (pend[t] && !got) begin
          got = 1'b1;
          a   = v.addrs[t*28 +: 28];
        end
      end
      sel = '0;
      for (int t = 0; t < 4; t++) sel[t] = pend[t] && (v.addrs[t*28 +: 28] == a);
      e.we   = '0;
      e.data = '0;
      for (int b = 0; b < 16; b++) begin
        got = 1'b0;
        for (int t = 3; t >= 0; t--) begin
          off = int'(v.offs[t*4 +: 4]);
          if (!got && sel[t] && b >= off && b < off + sz) begin
            got = 1'b1;
            e.we[b] = 1'b1;
            if (b - off < 4) e.data[b*8 +: 8] = v.wdata[t*32 + (b - off)*8 +: 8];
          end
        end
      end
      pend   = pend & ~sel;
      e.addr = a;
      e.tag  = v.tag;
      e.last = (pend == 4'b0);
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    wexp_t e;
`ifndef BGPU_WDATA_COALESCER_MISALIGN_DROP_EN
    check("err_tied_low", 128'(err), 128'(0));
`endif
    if (mem_valid && mem_ready) begin
      if (obs_total == base_total) begin
        first_addr = mem_addr;
        first_we   = mem_we;
      end
      obs_total++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h we %h, expected no write", mem_addr, mem_we);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 128'(mem_addr), 128'(e.addr));
        check("wr_we", 128'(mem_we), 128'(e.we));
        check("wr_data", mem_wdata, e.data);
        check("wr_tag", 128'(mem_tag), 128'(e.tag));
        check("wr_last", 128'(mem_last), 128'(e.last));
      end
    end
  endtask

  // Sample at the falling edge, then advance to just past the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    req_valid = 1'b1;
    req_mask  = v.mask;
    req_tag   = v.tag;
    req_width = v.width;
    req_addr  = v.addrs;
    req_offs  = v.offs;
    req_wdata = v.wdata;
    push_model(v);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (req_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: req_ready_o %b, expected 1 within 60 cycles", req_ready);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    base_total = obs_total;
    send(v);
    wait_idle();
    check({name, "_writes"}, 128'(obs_total - base_total), 128'(v.exp_writes));
    if (v.exp_writes > 0) begin
      check({name, "_first_addr"}, 128'(first_addr), 128'(v.exp_first_addr));
      check({name, "_first_we"}, 128'(first_we), 128'(v.exp_first_we));
    end
    check({name, "_sb_empty"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    logic [27:0]  s_addr;
    logic [15:0]  s_we;
    logic [127:0] s_data;
    logic [3:0]   s_tag;
    logic         s_last;
    vec_t         v;

    // Single block merge; distinct blocks; overlap; block-end; single thread; all distinct.
    vecs.push_back(mkv(4'b1111, 4'h1, 2'd2, pa(16, 16, 16, 16), po(0, 4, 8, 12),
                       {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1, 28'h10, 16'hFFFF));
    vecs.push_back(mkv(4'b1111, 4'h2, 2'd2, pa(1, 2, 1, 3), po(0, 4, 8, 12),
                       {32'hD3D2D1D0, 32'hC3C2C1C0, 32'hB3B2B1B0, 32'hA3A2A1A0}, 3, 28'h1, 16'h0F0F));
    vecs.push_back(mkv(4'b1010, 4'h3, 2'd0, pa(0, 5, 0, 5), po(0, 0, 0, 0),
                       {32'h000000BB, 32'h0, 32'h000000AA, 32'h0}, 1, 28'h5, 16'h0001));
`ifndef BGPU_WDATA_COALESCER_MISALIGN_DROP_EN
    vecs.push_back(mkv(4'b0001, 4'h4, 2'd2, pa(7, 0, 0, 0), po(14, 0, 0, 0),
                       {96'h0, 32'h87654321}, 1, 28'h7, 16'hC000));
`endif
    vecs.push_back(mkv(4'b0100, 4'h6, 2'd1, pa(0, 0, 3, 0), po(0, 0, 6, 0),
                       {32'h0, 32'h0000BEEF, 64'h0}, 1, 28'h3, 16'h00C0));
    vecs.push_back(mkv(4'b1111, 4'h7, 2'd0, pa(9, 8, 7, 6), po(1, 2, 3, 4),
                       {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011}, 4, 28'h9, 16'h0002));

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mask  = '0;
    req_tag   = '0;
    req_width = '0;
    req_addr  = '0;
    req_offs  = '0;
    req_wdata = '0;
    mem_ready = 1'b1;

    #2;
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_mem_valid", 128'(mem_valid), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_mem_tag", 128'(mem_tag), 128'(0));
    check("rst_mem_last", 128'(mem_last), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Zero mask: accepted, nothing written, stays ready.
    v = mkv(4'b0000, 4'h5, 2'd2, pa(1, 2, 3, 4), po(0, 4, 8, 12), {4{32'hDEADBEEF}}, 0, '0, '0);
    base_total = obs_total;
    send(v);
    for (int i = 0; i < 3; i++) begin
      check("zero_ready", 128'(req_ready), 128'(1));
      check("zero_valid", 128'(mem_valid), 128'(0));
      step();
    end
    check("zero_writes", 128'(obs_total - base_total), 128'(0));

    // Backpressure: first write goes through, then a 5-cycle stall.
    mem_ready  = 1'b0;
    base_total = obs_total;
    send(vecs[1]);
    check("bp_valid", 128'(mem_valid), 128'(1));
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    s_addr = mem_addr; s_we = mem_we; s_data = mem_wdata; s_tag = mem_tag; s_last = mem_last;
    check("bp_second_addr", 128'(s_addr), 128'(2));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 128'(mem_valid), 128'(1));
      check("bp_hold_ready", 128'(req_ready), 128'(0));
      check("bp_hold_addr", 128'(mem_addr), 128'(s_addr));
      check("bp_hold_we", 128'(mem_we), 128'(s_we));
      check("bp_hold_data", mem_wdata, s_data);
      check("bp_hold_tag", 128'(mem_tag), 128'(s_tag));
      check("bp_hold_last", 128'(mem_last), 128'(s_last));
    end
    mem_ready = 1'b1;
    wait_idle();
    check("bp_writes", 128'(obs_total - base_total), 128'(3));
    check("bp_sb_empty", 128'(sb.size()), 128'(0));

    // Reset while busy: in-flight request is discarded.
    mem_ready = 1'b0;
    send(vecs[1]);
    check("rb_busy", 128'(mem_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_valid_low", 128'(mem_valid), 128'(0));
    check("rb_we_low", 128'(mem_we), 128'(0));
    check("rb_last_low", 128'(mem_last), 128'(0));
    check("rb_ready", 128'(req_ready), 128'(1));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    base_total = obs_total;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rb_post_ready", 128'(req_ready), 128'(1));
      check("rb_post_valid", 128'(mem_valid), 128'(0));
    end
    check("rb_no_writes", 128'(obs_total - base_total), 128'(0));
    run_vec(vecs[2], "rb_recover");

`ifdef BGPU_WDATA_COALESCER_MISALIGN_DROP_EN
    // Thread 0 at offset 2 with 4-byte width is dropped; thread 1 survives.
    v = mkv(4'b0011, 4'h9, 2'd2, pa(4, 4, 0, 0), po(2, 4, 0, 0),
            {64'h0, 32'h55667788, 32'h11223344}, 1, 28'h4, 16'h00F0);
    base_total = obs_total;
    send(v);
    check("mis_err_pulse", 128'(err), 128'(1));
    step();
    check("mis_err_clear", 128'(err), 128'(0));
    if (!req_ready) wait_idle();
    check("mis_writes", 128'(obs_total - base_total), 128'(1));
    check("mis_first_we", 128'(first_we), 128'(16'h00F0));
    // Only thread crosses the block end: dropped, no write, stays idle.
    v = mkv(4'b0001, 4'hA, 2'd2, pa(7, 0, 0, 0), po(14, 0, 0, 0), {96'h0, 32'h87654321}, 0, '0, '0);
    base_total = obs_total;
    send(v);
    check("mis_all_err", 128'(err), 128'(1));
    check("mis_all_ready", 128'(req_ready), 128'(1));
    step();
    check("mis_all_valid", 128'(mem_valid), 128'(0));
    check("mis_all_writes", 128'(obs_total - base_total), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
